// File: rtl/dcache_wb_pkg.sv
// Shared types and default geometry for the write-back data cache.
package dcache_wb_pkg;

    localparam int unsigned DEF_NLINES     = 4;
    localparam int unsigned DEF_LINE_BITS  = 128;
    localparam int unsigned DEF_ADDR_WIDTH = 20;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        REFILL_REQ,
        REFILL_WAIT,
        FLUSH_SCAN,
        FLUSH_WB
    } dcache_state_t;

    // Line-store write-port operations.
    typedef enum logic [1:0] {
        WR_NONE,
        WR_FILL,
        WR_STORE,
        WR_INVAL
    } dcache_wr_op_t;

endpackage

// File: rtl/dcache_wb_if.sv
// CPU request/response and line-wide memory port bundle for dcache_wb.
interface dcache_wb_if
    import dcache_wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned LINE_BITS  = DEF_LINE_BITS
);
    localparam int unsigned BE_W = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [BE_W-1:0]       req_be;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  flush_req;
    logic                  flush_done;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_write;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [LINE_BITS-1:0]  mem_wdata;
    logic                  mem_rsp_valid;
    logic [LINE_BITS-1:0]  mem_rdata;

    // Cache side.
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, flush_req,
               mem_req_ready, mem_rsp_valid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, flush_done,
               mem_req_valid, mem_req_write, mem_req_addr, mem_wdata
    );

    // Core + memory side.
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, flush_req,
               mem_req_ready, mem_rsp_valid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, flush_done,
               mem_req_valid, mem_req_write, mem_req_addr, mem_wdata
    );

endinterface

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data arrays: one async read port, one write port with
// line fill, byte-enable word merge and line invalidate.
module dcache_line_store
    import dcache_wb_pkg::*;
#(
    parameter int unsigned NLINES     = DEF_NLINES,
    parameter int unsigned LINE_BITS  = DEF_LINE_BITS,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned TAG_W      = 14,
    localparam int unsigned IDX_W     = $clog2(NLINES),
    localparam int unsigned WORDS     = LINE_BITS / DATA_WIDTH,
    localparam int unsigned WSEL_W    = (WORDS > 1) ? $clog2(WORDS) : 1,
    localparam int unsigned BE_W      = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic                  rd_valid_o,
    output logic                  rd_dirty_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [LINE_BITS-1:0]  rd_line_o,
    input  dcache_wr_op_t         wr_op_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [LINE_BITS-1:0]  wr_line_i,
    input  logic [WSEL_W-1:0]     wr_word_i,
    input  logic [DATA_WIDTH-1:0] wr_wdata_i,
    input  logic [BE_W-1:0]       wr_be_i
);
    typedef logic [WORDS-1:0][DATA_WIDTH-1:0] words_t;

    logic [NLINES-1:0]    valid_q;
    logic [NLINES-1:0]    dirty_q;
    logic [TAG_W-1:0]     tag_q  [NLINES];
    logic [LINE_BITS-1:0] data_q [NLINES];
    words_t               merged_d;

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_dirty_o = dirty_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_line_o  = data_q[rd_idx_i];

    // Store data merged into the target line byte by byte.
    always_comb begin
        merged_d = data_q[wr_idx_i];
        for (int unsigned b = 0; b < BE_W; b++) begin
            if (wr_be_i[b]) begin
                merged_d[wr_word_i][b*8 +: 8] = wr_wdata_i[b*8 +: 8];
            end
        end
    end

    // Line state bits; cleared asynchronously so reset invalidates the cache.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            case (wr_op_i)
                WR_FILL: begin
                    valid_q[wr_idx_i] <= 1'b1;
                    dirty_q[wr_idx_i] <= 1'b0;
                end
                WR_STORE: dirty_q[wr_idx_i] <= 1'b1;
                WR_INVAL: begin
                    valid_q[wr_idx_i] <= 1'b0;
                    dirty_q[wr_idx_i] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Tag and data payload; never reset, only meaningful while valid.
    always_ff @(posedge clk_i) begin
        case (wr_op_i)
            WR_FILL: begin
                tag_q[wr_idx_i]  <= wr_tag_i;
                data_q[wr_idx_i] <= wr_line_i;
            end
            WR_STORE: data_q[wr_idx_i] <= merged_d;
            default: ;
        endcase
    end

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with software flush.
module dcache_wb
    import dcache_wb_pkg::*;
#(
    parameter int unsigned NLINES     = DEF_NLINES,
    parameter int unsigned LINE_BITS  = DEF_LINE_BITS,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input logic         clk,
    input logic         rst_n,
    dcache_wb_if.slave  bus
);
    localparam int unsigned BE_W   = DATA_WIDTH / 8;
    localparam int unsigned OFF    = $clog2(LINE_BITS / 8);
    localparam int unsigned BOFF   = $clog2(BE_W);
    localparam int unsigned IDX_W  = $clog2(NLINES);
    localparam int unsigned TAG_W  = ADDR_WIDTH - IDX_W - OFF;
    localparam int unsigned WORDS  = LINE_BITS / DATA_WIDTH;
    localparam int unsigned WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef logic [WORDS-1:0][DATA_WIDTH-1:0] words_t;

    dcache_state_t            state_q;
    logic                     req_write_q;
    logic [ADDR_WIDTH-1:BOFF] req_addr_q;
    logic [DATA_WIDTH-1:0]    req_wdata_q;
    logic [BE_W-1:0]          req_be_q;
    logic [IDX_W-1:0]         flush_idx_q;
    logic                     mem_req_valid_q;
    logic                     mem_req_write_q;
    logic [ADDR_WIDTH-1:0]    mem_req_addr_q;
    logic [LINE_BITS-1:0]     mem_wdata_q;
    logic                     flush_done_q;

    logic [TAG_W-1:0]         req_tag;
    logic [IDX_W-1:0]         req_idx;
    logic [WSEL_W-1:0]        word_sel;
    logic                     flushing;
    logic [IDX_W-1:0]         idx_d;
    logic                     rd_valid;
    logic                     rd_dirty;
    logic [TAG_W-1:0]         rd_tag;
    logic [LINE_BITS-1:0]     rd_line;
    words_t                   rd_words;
    logic                     hit;
    logic                     last_idx;
    logic [ADDR_WIDTH-1:0]    victim_addr;
    logic [ADDR_WIDTH-1:0]    refill_addr;
    dcache_wr_op_t            wr_op_d;

    assign req_tag = req_addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign req_idx = req_addr_q[OFF +: IDX_W];

    if (WORDS > 1) begin : g_wsel
        assign word_sel = req_addr_q[OFF-1:BOFF];
    end else begin : g_wsel_one
        assign word_sel = '0;
    end

    // One read/write index serves both the request path and the flush walk.
    assign flushing    = (state_q == FLUSH_SCAN) || (state_q == FLUSH_WB);
    assign idx_d       = flushing ? flush_idx_q : req_idx;
    assign rd_words    = rd_line;
    assign hit         = rd_valid && (rd_tag == req_tag);
    assign last_idx    = (flush_idx_q == IDX_W'(NLINES - 1));
    assign victim_addr = {rd_tag, idx_d, {OFF{1'b0}}};
    assign refill_addr = {req_tag, req_idx, {OFF{1'b0}}};

    dcache_line_store #(
        .NLINES     (NLINES),
        .LINE_BITS  (LINE_BITS),
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_W      (TAG_W)
    ) u_store (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rd_idx_i   (idx_d),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .rd_tag_o   (rd_tag),
        .rd_line_o  (rd_line),
        .wr_op_i    (wr_op_d),
        .wr_idx_i   (idx_d),
        .wr_tag_i   (req_tag),
        .wr_line_i  (bus.mem_rdata),
        .wr_word_i  (word_sel),
        .wr_wdata_i (req_wdata_q),
        .wr_be_i    (req_be_q)
    );

    // Line-store update selected by the current state.
    always_comb begin
        wr_op_d = WR_NONE;
        case (state_q)
            COMPARE:     if (hit && req_write_q)  wr_op_d = WR_STORE;
            REFILL_WAIT: if (bus.mem_rsp_valid)   wr_op_d = WR_FILL;
            FLUSH_SCAN:  if (!rd_dirty)           wr_op_d = WR_INVAL;
            FLUSH_WB:    if (bus.mem_req_ready)   wr_op_d = WR_INVAL;
            default: ;
        endcase
    end

    // Control FSM; memory-port outputs are loaded on entry to each request
    // state so they stay stable until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            req_write_q     <= 1'b0;
            req_addr_q      <= '0;
            req_wdata_q     <= '0;
            req_be_q        <= '0;
            flush_idx_q     <= '0;
            mem_req_valid_q <= 1'b0;
            mem_req_write_q <= 1'b0;
            mem_req_addr_q  <= '0;
            mem_wdata_q     <= '0;
            flush_done_q    <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.flush_req) begin
                        flush_idx_q <= '0;
                        state_q     <= FLUSH_SCAN;
                    end else if (bus.req_valid) begin
                        req_write_q <= bus.req_write;
                        req_addr_q  <= bus.req_addr[ADDR_WIDTH-1:BOFF];
                        req_wdata_q <= bus.req_wdata;
                        req_be_q    <= bus.req_be;
                        state_q     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        state_q <= IDLE;
                    end else if (rd_valid && rd_dirty) begin
                        mem_req_valid_q <= 1'b1;
                        mem_req_write_q <= 1'b1;
                        mem_req_addr_q  <= victim_addr;
                        mem_wdata_q     <= rd_line;
                        state_q         <= WRITEBACK;
                    end else begin
                        mem_req_valid_q <= 1'b1;
                        mem_req_write_q <= 1'b0;
                        mem_req_addr_q  <= refill_addr;
                        state_q         <= REFILL_REQ;
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_req_ready) begin
                        mem_req_write_q <= 1'b0;
                        mem_req_addr_q  <= refill_addr;
                        mem_wdata_q     <= '0;
                        state_q         <= REFILL_REQ;
                    end
                end
                REFILL_REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        mem_req_addr_q  <= '0;
                        state_q         <= REFILL_WAIT;
                    end
                end
                REFILL_WAIT: begin
                    if (bus.mem_rsp_valid) state_q <= COMPARE;
                end
                FLUSH_SCAN: begin
                    if (rd_dirty) begin
                        mem_req_valid_q <= 1'b1;
                        mem_req_write_q <= 1'b1;
                        mem_req_addr_q  <= victim_addr;
                        mem_wdata_q     <= rd_line;
                        state_q         <= FLUSH_WB;
                    end else if (last_idx) begin
                        flush_idx_q  <= '0;
                        flush_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        flush_idx_q <= flush_idx_q + IDX_W'(1);
                    end
                end
                FLUSH_WB: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        mem_req_write_q <= 1'b0;
                        mem_req_addr_q  <= '0;
                        mem_wdata_q     <= '0;
                        // The last line finishes the flush directly rather
                        // than taking another scan cycle.
                        if (last_idx) begin
                            flush_idx_q  <= '0;
                            flush_done_q <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            flush_idx_q <= flush_idx_q + IDX_W'(1);
                            state_q     <= FLUSH_SCAN;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.rsp_valid     = (state_q == COMPARE) && hit;
    assign bus.rsp_rdata     = ((state_q == COMPARE) && hit && !req_write_q) ? rd_words[word_sel] : '0;
    assign bus.flush_done    = flush_done_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_write = mem_req_write_q;
    assign bus.mem_req_addr  = mem_req_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb at default geometry.
module tb_dcache_wb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dcache_wb_if #(.ADDR_WIDTH(20), .DATA_WIDTH(32), .LINE_BITS(128)) bus ();

    dcache_wb #(
        .NLINES     (4),
        .LINE_BITS  (128),
        .ADDR_WIDTH (20),
        .DATA_WIDTH (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] L1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] L2 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] L3 = 128'h88888888_77777777_66666666_55555555;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_ready();
        for (int c = 0; c < 20 && !bus.req_ready; c++) step();
    endtask

    // Issues one request and acts as zero-wait memory until rsp_valid.
    task automatic run_req(input logic wr, input logic [19:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, input logic [127:0] fill,
                           output logic got, output logic [31:0] rdata,
                           output int nrd, output logic [19:0] raddr);
        logic pending;
        got = 1'b0; rdata = '0; nrd = 0; raddr = '0; pending = 1'b0;
        bus.mem_req_ready = 1'b1;
        wait_ready();
        bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr;
        bus.req_wdata = wd; bus.req_be = be;
        step();
        bus.req_valid = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            bus.mem_rsp_valid = 1'b0;
            if (bus.rsp_valid) begin
                got = 1'b1;
                rdata = bus.rsp_rdata;
            end else begin
                if (pending) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rdata = fill;
                    pending = 1'b0;
                end else if (bus.mem_req_valid && !bus.mem_req_write) begin
                    nrd++;
                    raddr = bus.mem_req_addr;
                    pending = 1'b1;
                end
                step();
            end
        end
        bus.mem_rsp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b want 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp got %0b/%h want 0/0", bus.rsp_valid, bus.rsp_rdata); end
        checks++; if (bus.flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done got %0b want 0", bus.flush_done); end
        checks++; if (bus.mem_req_valid !== 1'b0 || bus.mem_req_write !== 1'b0) begin errors++; $display("FAIL reset_mem_ctl got %0b/%0b want 0/0", bus.mem_req_valid, bus.mem_req_write); end
        checks++; if (bus.mem_req_addr !== 20'h0 || bus.mem_wdata !== 128'h0) begin errors++; $display("FAIL reset_mem_data got %h/%h want 0/0", bus.mem_req_addr, bus.mem_wdata); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_miss_refill();
        bus.mem_req_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 20'h00040;
        bus.req_wdata = '0; bus.req_be = '0;
        step();  // COMPARE
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_req_valid !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL miss_compare got memv=%0b rspv=%0b want 0/0", bus.mem_req_valid, bus.rsp_valid); end
        step();  // REFILL_REQ
        checks++; if ({bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr} !== {1'b1, 1'b0, 20'h00040}) begin errors++; $display("FAIL miss_read_req got v=%0b w=%0b a=%h want 1/0/00040", bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr); end
        step();  // REFILL_WAIT
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL miss_req_drop got %0b want 0", bus.mem_req_valid); end
        bus.mem_rsp_valid = 1'b1; bus.mem_rdata = L1;
        step();  // COMPARE hit, acceptance + 4
        bus.mem_rsp_valid = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h11111111) begin errors++; $display("FAIL miss_rsp got %0b/%h want 1/11111111", bus.rsp_valid, bus.rsp_rdata); end
        step();  // IDLE
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 20'h00048;
        step();
        bus.req_valid = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h33333333) begin errors++; $display("FAIL hit_rsp got %0b/%h want 1/33333333", bus.rsp_valid, bus.rsp_rdata); end
        step();
        checks++; if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL hit_ready_next got rdy=%0b rspv=%0b want 1/0", bus.req_ready, bus.rsp_valid); end
    endtask

    task automatic test_store_merge();
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 20'h00044;
        bus.req_wdata = 32'h0000AB00; bus.req_be = 4'b0010;
        step();
        bus.req_valid = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL store_rsp got %0b/%h want 1/0", bus.rsp_valid, bus.rsp_rdata); end
        step();
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 20'h00044;
        step();
        bus.req_valid = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h2222AB22) begin errors++; $display("FAIL store_merge got %0b/%h want 1/2222ab22", bus.rsp_valid, bus.rsp_rdata); end
        step();
    endtask

    task automatic test_dirty_evict();
        logic [127:0] wb_line;
        wb_line = 128'h44444444_33333333_2222AB22_11111111;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 20'h00080;
        step();  // COMPARE, victim dirty
        bus.req_valid = 1'b0;
        bus.mem_req_ready = 1'b0;
        step();  // WRITEBACK
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr, bus.mem_wdata} !== {1'b1, 1'b1, 20'h00040, wb_line}) begin
                errors++;
                $display("FAIL evict_hold[%0d] got v=%0b w=%0b a=%h d=%h want 1/1/00040/%h", i, bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr, bus.mem_wdata, wb_line);
            end
            step();
        end
        bus.mem_req_ready = 1'b1;
        step();  // REFILL_REQ
        checks++; if ({bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr} !== {1'b1, 1'b0, 20'h00080}) begin errors++; $display("FAIL evict_refill_req got v=%0b w=%0b a=%h want 1/0/00080", bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr); end
        step();  // REFILL_WAIT
        bus.mem_rsp_valid = 1'b1; bus.mem_rdata = L2;
        step();
        bus.mem_rsp_valid = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hAAAAAAAA) begin errors++; $display("FAIL evict_rsp got %0b/%h want 1/aaaaaaaa", bus.rsp_valid, bus.rsp_rdata); end
        step();
    endtask

    task automatic test_flush();
        logic got; logic [31:0] rd; int nrd; logic [19:0] ra;
        logic [19:0] wa [4]; logic [127:0] wd [4]; logic ww [4];
        int nw; logic done;
        run_req(1'b1, 20'h0008C, 32'h12340000, 4'b1100, L2, got, rd, nrd, ra);
        checks++; if (!got || nrd != 0) begin errors++; $display("FAIL flush_setup0 got rsp=%0b reads=%0d want 1/0", got, nrd); end
        run_req(1'b1, 20'h00024, 32'hCAFEF00D, 4'b1111, L3, got, rd, nrd, ra);
        checks++; if (!got || nrd != 1 || ra !== 20'h00020) begin errors++; $display("FAIL flush_setup2 got rsp=%0b reads=%0d a=%h want 1/1/00020", got, nrd, ra); end
        wait_ready();
        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        nw = 0; done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            if (bus.flush_done) done = 1'b1;
            else begin
                if (bus.mem_req_valid && bus.mem_req_ready) begin
                    if (nw < 4) begin wa[nw] = bus.mem_req_addr; wd[nw] = bus.mem_wdata; ww[nw] = bus.mem_req_write; end
                    nw++;
                end
                step();
            end
        end
        checks++; if (!done || nw != 2) begin errors++; $display("FAIL flush_count got done=%0b writes=%0d want 1/2", done, nw); end
        if (nw >= 2) begin
            checks++; if ({ww[0], wa[0], wd[0]} !== {1'b1, 20'h00080, 128'h1234DDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA}) begin errors++; $display("FAIL flush_wb0 got w=%0b a=%h d=%h want 1/00080/1234ddddccccccccbbbbbbbbaaaaaaaa", ww[0], wa[0], wd[0]); end
            checks++; if ({ww[1], wa[1], wd[1]} !== {1'b1, 20'h00020, 128'h88888888_77777777_CAFEF00D_55555555}) begin errors++; $display("FAIL flush_wb1 got w=%0b a=%h d=%h want 1/00020/8888888877777777cafef00d55555555", ww[1], wa[1], wd[1]); end
        end
        run_req(1'b0, 20'h00080, 32'h0, 4'b0000, L2, got, rd, nrd, ra);
        checks++; if (!got || nrd != 1 || ra !== 20'h00080 || rd !== 32'hAAAAAAAA) begin errors++; $display("FAIL flush_then_miss got rsp=%0b reads=%0d a=%h d=%h want 1/1/00080/aaaaaaaa", got, nrd, ra, rd); end
    endtask

    task automatic test_flush_collide();
        int done_at; logic stray;
        wait_ready();
        bus.flush_req = 1'b1;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 20'h00040;
        step();
        bus.flush_req = 1'b0; bus.req_valid = 1'b0;
        done_at = 0; stray = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (bus.flush_done && done_at == 0) done_at = c;
            if (bus.rsp_valid || bus.mem_req_valid) stray = 1'b1;
            step();
        end
        checks++; if (done_at != 5) begin errors++; $display("FAIL flush_clean_timing got %0d want 5", done_at); end
        checks++; if (stray !== 1'b0) begin errors++; $display("FAIL flush_wins got stray=%0b want 0", stray); end
    endtask

    task automatic test_reset_mid();
        logic got; logic [31:0] rd; int nrd; logic [19:0] ra; logic seen; logic rsp_seen;
        bus.mem_req_ready = 1'b1;
        wait_ready();
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 20'h00040;
        step();
        bus.req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (bus.mem_req_valid && !bus.mem_req_write) seen = 1'b1;
            step();
        end
        checks++; if (!seen) begin errors++; $display("FAIL rstmid_read_req got 0 want 1"); end
        rst_n = 1'b0;  // now in REFILL_WAIT
        #1;
        checks++; if (bus.mem_req_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_abort got memv=%0b rdy=%0b want 0/1", bus.mem_req_valid, bus.req_ready); end
        step(); step();
        rst_n = 1'b1;
        bus.mem_rsp_valid = 1'b1; bus.mem_rdata = L1;
        rsp_seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            bus.mem_rsp_valid = 1'b0;
            if (bus.rsp_valid) rsp_seen = 1'b1;
        end
        checks++; if (rsp_seen !== 1'b0) begin errors++; $display("FAIL rstmid_no_rsp got 1 want 0"); end
        run_req(1'b0, 20'h00040, 32'h0, 4'b0000, L2, got, rd, nrd, ra);
        checks++; if (!got || nrd != 1 || ra !== 20'h00040 || rd !== 32'hAAAAAAAA) begin errors++; $display("FAIL rstmid_next_miss got rsp=%0b reads=%0d a=%h d=%h want 1/1/00040/aaaaaaaa", got, nrd, ra, rd); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0; bus.req_be = '0; bus.flush_req = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rdata = '0;
        rst_n = 1'b0;
        test_reset();
        test_miss_refill();
        test_store_merge();
        test_dirty_evict();
        test_flush();
        test_flush_collide();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule

// File: doc/dcache_wb.md
# dcache_wb

Parametrised direct-mapped, write-back, write-allocate data cache sitting between the core's load/store unit and the line-wide memory port. It generalises the fixed data-cache geometry of the core: line count, line width, address width and word width are parameters. It adds dirty-line eviction, byte-enable stores and a software-triggered flush.

## Interface
- NLINES, 4: number of lines; power of two, ≥2.
- LINE_BITS, 128: line width in bits; power-of-two multiple of DATA_WIDTH.
- ADDR_WIDTH, 20: physical byte-address width.
- DATA_WIDTH, 32: CPU word width; BE_W = DATA_WIDTH/8.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  cache accepts request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address; low log2(BE_W) bits ignored.
- req_wdata  in  DATA_WIDTH  store data.
- req_be  in  BE_W  store byte enables.
- rsp_valid  out  1  one-cycle pulse; load data or store completion.
- rsp_rdata  out  DATA_WIDTH  load data; 0 for stores.
- flush_req  in  1  start flush; sampled only in IDLE.
- flush_done  out  1  one-cycle pulse at flush end.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_write  out  1  1 = line write-back, 0 = line read.
- mem_req_addr  out  ADDR_WIDTH  line-aligned address.
- mem_wdata  out  LINE_BITS  write-back line.
- mem_rsp_valid  in  1  refill data valid.
- mem_rdata  in  LINE_BITS  refill line.

## Operation
- Address split: OFF = log2(LINE_BITS/8), IDX = log2(NLINES), TAG = ADDR_WIDTH−IDX−OFF. Word select = addr[OFF−1:log2(BE_W)]; word 0 is line bits [DATA_WIDTH−1:0].
- Per line: valid, dirty, tag, data.
- FSM states: IDLE, COMPARE, WRITEBACK, REFILL_REQ, REFILL_WAIT, FLUSH_SCAN, FLUSH_WB.
- IDLE: req_ready=1. flush_req=1 → FLUSH_SCAN with index 0; flush wins over a simultaneous req_valid, which is not accepted. Otherwise req_valid → latch request, go to COMPARE.
- COMPARE, hit: load returns selected word. Store merges req_wdata per req_be and sets dirty. Both pulse rsp_valid, then IDLE.
- COMPARE, miss, victim valid and dirty: WRITEBACK. Otherwise: REFILL_REQ.
- WRITEBACK: mem_req_write=1, address {victim tag, idx, 0}, mem_wdata = victim line. Leaves on handshake to REFILL_REQ.
- REFILL_REQ: read request, address {req tag, idx, 0}. Leaves on handshake to REFILL_WAIT.
- REFILL_WAIT: on mem_rsp_valid, install line with valid=1, dirty=0, then COMPARE, which now hits.
- FLUSH_SCAN: for the current index, dirty → FLUSH_WB. Otherwise clear valid and advance. After index NLINES−1, pulse flush_done and go to IDLE.
- FLUSH_WB: write back the line; on handshake clear valid/dirty and return to FLUSH_SCAN at the next index.
- Memory handshake: at most one outstanding request. mem_req_valid, mem_req_addr, mem_req_write and mem_wdata are held stable until mem_req_ready. mem_rsp_valid outside REFILL_WAIT is ignored.
- Reset: state IDLE; all valid, dirty and flush index cleared. Tag/data arrays are not reset.

## Timing
- Reset values: req_ready=1 (IDLE), rsp_valid=0, rsp_rdata=0, flush_done=0, mem_req_valid=0, mem_req_write=0, mem_req_addr=0, mem_wdata=0.
- Hit: accepted cycle N, rsp_valid cycle N+1, req_ready again N+2; peak throughput one request per 2 cycles.
- Clean miss with zero-wait memory: rsp_valid = acceptance + 4 + memory response latency.
- Dirty miss: one extra handshake (WRITEBACK) before the refill.
- Flush with no dirty lines: flush_done exactly NLINES+1 cycles after flush_req is sampled.
- Reset mid-transaction: FSM aborts immediately, mem_req_valid drops, no rsp_valid is issued, and late memory responses are ignored.

## Structure
- Shared package: dcache_state_t enum and the default geometry constants (lines 4, line 128 bits, address 20 bits, word 32 bits). Tag/index/offset widths are derived in-module from the parameters.
- One sub-module, dcache_line_store: valid/dirty/tag/data arrays with one read port and one write port, byte-enable word merge, and async clear of valid/dirty.

## Test plan
- Defaults after reset: load 0x00040 → mem read 0x00040; return 128'h4444…_3333…_2222…_1111… → rsp_rdata=0x11111111. Load 0x00048 then hits, rsp_rdata=0x33333333, 1-cycle latency.
- Store 0x00044, be=4'b0010, wdata=0x0000AB00 on the resident line → load 0x00044 returns 0x2222AB22.
- Conflict: line 0x00040 dirty, then load 0x00080 → mem write 0x00040 with merged line, then read 0x00080, then rsp_valid.
- Hold mem_req_ready=0 for 5 cycles → mem_req_valid, mem_req_addr and mem_wdata stay constant.
- Flush with indices 0 and 2 dirty → two writes in index order, flush_done pulse, subsequent load misses. Same-cycle flush_req and req_valid → request not accepted.
- Assert rst_n=0 during REFILL_WAIT, then mem_rsp_valid after release → no install, no rsp_valid, next load misses.
